// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the single-clock FIFO.
package fifo_pkg;

  // Pointers and the level counter carry one extra wrap bit over the address.
  function automatic int ptr_w(input int asize);
    return asize + 1;
  endfunction

  function automatic bit thresh_ok(input int asize, input int afull, input int aempty);
    return (asize >= 1) && (aempty >= 0) && (aempty < afull) && (afull <= (1 << asize));
  endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Producer/consumer bundle for fifo_sync; master = user side, slave = FIFO side.
interface fifo_sync_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             walmost_full;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   level;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  modport master (
    output wdata, winc, rinc, err_clr,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, level, overflow, underflow
  );

  modport slave (
    input  wdata, winc, rinc, err_clr,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_mem.sv
// 2^ASIZE x DSIZE storage: synchronous write, asynchronous read, no reset.
module fifo_sync_mem #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);
  localparam int DEPTH = 1 << ASIZE;

  logic [DEPTH-1:0][DSIZE-1:0] r_mem;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with level, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DSIZE         = 32,
  parameter int ASIZE         = 5,
  parameter int AFULL_THRESH  = 28,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  fifo_sync_if.slave bus
);
  localparam int PW = ptr_w(ASIZE);

  generate
    if (!thresh_ok(ASIZE, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
      $error("fifo_sync: need AEMPTY_THRESH < AFULL_THRESH <= 2^ASIZE");
    end
  endgenerate

  logic [PW-1:0]    r_wptr, r_rptr, r_level;
  logic             r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;
  logic [PW-1:0]    w_wptr_nxt, w_rptr_nxt, w_level_nxt;
  logic             w_wr, w_rd;
  logic [DSIZE-1:0] w_mem_rdata;

  // Acceptance uses the registered flags, so winc/rinc never reach the flags combinationally.
  assign w_wr        = bus.winc & ~r_full;
  assign w_rd        = bus.rinc & ~r_empty;
  assign w_wptr_nxt  = r_wptr + PW'(w_wr);
  assign w_rptr_nxt  = r_rptr + PW'(w_rd);
  assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_wptr_nxt[PW-1] != w_rptr_nxt[PW-1]) &&
                  (w_wptr_nxt[ASIZE-1:0] == w_rptr_nxt[ASIZE-1:0]);
      r_empty  <= (w_wptr_nxt == w_rptr_nxt);
      r_afull  <= (w_level_nxt >= PW'(AFULL_THRESH));
      r_aempty <= (w_level_nxt <= PW'(AEMPTY_THRESH));
      // A new error outranks a coincident clear.
      r_ovf    <= (bus.winc & r_full)  | (r_ovf & ~bus.err_clr);
      r_udf    <= (bus.rinc & r_empty) | (r_udf & ~bus.err_clr);
    end
  end

  fifo_sync_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .i_clk   (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (bus.wdata),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (w_mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head entry is already visible; masked to zero while empty.
  assign bus.rdata = r_empty ? '0 : w_mem_rdata;
`else
  logic [DSIZE-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (w_rd) r_rdata <= w_mem_rdata;
  end

  assign bus.rdata = r_rdata;
`endif

  assign bus.wfull         = r_full;
  assign bus.walmost_full  = r_afull;
  assign bus.rempty        = r_empty;
  assign bus.ralmost_empty = r_aempty;
  assign bus.level         = r_level;
  assign bus.overflow      = r_ovf;
  assign bus.underflow     = r_udf;
endmodule
